// File: rtl/bit_serial_adder_if.sv
// Request/response handshake bundle for bit_serial_adder: operands and carry-in
// travel on the request side, the sum and carry-out on the response side.
interface bit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data_a;
    logic [WIDTH-1:0] i_data_b;
    logic             i_carry;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_carry;

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_carry, i_ready,
        output o_ready, o_valid, o_data, o_carry
    );

    modport master (
        output i_valid, i_data_a, i_data_b, i_carry, i_ready,
        input  o_ready, o_valid, o_data, o_carry
    );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell evaluated once per clock, LSB first,
// with the carry held in a flop between bits and the sum shifted in from the MSB.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    bit_serial_adder_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             carry_q,   carry_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             cell_sum;
    logic             cell_carry;

    full_adder_with_half_adder u_cell (
        .a    (shift_a_q[0]),
        .b    (shift_b_q[0]),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_carry)
    );

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    shift_a_d = bus.i_data_a;
                    shift_b_d = bus.i_data_b;
                    carry_d   = bus.i_carry;
                    result_d  = '0;
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Written as shift-then-overwrite so WIDTH=1 needs no special case.
                result_d           = result_q >> 1;
                result_d[WIDTH-1]  = cell_sum;
                carry_d            = cell_carry;
                shift_a_d          = shift_a_q >> 1;
                shift_b_d          = shift_b_q >> 1;
                cnt_d              = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
        end
    end

    // Handshake outputs decode state only; data is gated to zero outside DONE.
    assign bus.o_ready = (state_q == IDLE);
    assign bus.o_valid = (state_q == DONE);
    assign bus.o_data  = (state_q == DONE) ? result_q : '0;
    assign bus.o_carry = (state_q == DONE) ? carry_q  : 1'b0;
endmodule

module full_adder_with_half_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s0),  .cout(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .sum(sum), .cout(c1));

    assign cout = c0 | c1;
endmodule

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH 8, 1 and 13, all sharing one
// clock and reset; slot 0 (WIDTH=8) carries the directed scenarios.
module tb_bit_serial_adder;
    localparam int NS = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        v_in [NS];
    logic [63:0] a_in [NS];
    logic [63:0] b_in [NS];
    logic        c_in [NS];
    logic        r_in [NS];
    wire         rdy_o [NS];
    wire         v_o   [NS];
    wire         c_o   [NS];
    wire  [63:0] d_o   [NS];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < NS; g++) begin : g_dut
        localparam int W = (g == 0) ? 8 : ((g == 1) ? 1 : 13);
        bit_serial_adder_if #(.WIDTH(W)) bus ();
        bit_serial_adder #(.WIDTH(W)) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus)
        );
        assign bus.i_valid  = v_in[g];
        assign bus.i_data_a = a_in[g][W-1:0];
        assign bus.i_data_b = b_in[g][W-1:0];
        assign bus.i_carry  = c_in[g];
        assign bus.i_ready  = r_in[g];
        assign rdy_o[g]     = bus.o_ready;
        assign v_o[g]       = bus.o_valid;
        assign c_o[g]       = bus.o_carry;
        assign d_o[g]       = 64'(bus.o_data);
    end

    function automatic int width_of(input int s);
        return (s == 0) ? 8 : ((s == 1) ? 1 : 13);
    endfunction

    function automatic logic [63:0] mask_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on slot s and collect its result; scramble changes the operand
    // inputs (and i_ready) every cycle after accept, rgap holds i_ready low in DONE.
    task automatic run_req(input int s, input logic [63:0] a, input logic [63:0] b,
                           input logic c, input int rgap, input bit scramble,
                           output logic [63:0] d, output logic co, output int lat);
        int n;
        v_in[s] = 1'b1;
        a_in[s] = a;
        b_in[s] = b;
        c_in[s] = c;
        r_in[s] = 1'b0;
        n = 0;
        while (!rdy_o[s] && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("accept_timeout", 64'd0, 64'd1);
        tick();
        v_in[s] = 1'b0;
        lat = 0;
        while (!v_o[s] && lat < 100) begin
            if (scramble) begin
                a_in[s] = {$urandom, $urandom};
                b_in[s] = {$urandom, $urandom};
                c_in[s] = 1'($urandom);
                r_in[s] = 1'($urandom);
            end
            tick();
            lat++;
        end
        if (lat == 100) check("done_timeout", 64'd0, 64'd1);
        r_in[s] = 1'b0;
        repeat (rgap) tick();
        d  = d_o[s];
        co = c_o[s];
        r_in[s] = 1'b1;
        tick();
        r_in[s] = 1'b0;
    endtask

    logic [63:0] vec_a [4] = '{64'hFF, 64'hFF, 64'h00, 64'h5A};
    logic [63:0] vec_b [4] = '{64'h01, 64'hFF, 64'h00, 64'h3C};
    logic        vec_c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] vec_d [4] = '{64'h00, 64'hFF, 64'h01, 64'h96};
    logic        vec_o [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [63:0] d;
        logic [63:0] held_d;
        logic        co;
        int          lat;
        int          seen;

        for (int s = 0; s < NS; s++) begin
            v_in[s] = 1'b0;
            a_in[s] = '0;
            b_in[s] = '0;
            c_in[s] = 1'b0;
            r_in[s] = 1'b0;
        end

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(rdy_o[0]), 64'd1);
        check("rst_valid", 64'(v_o[0]), 64'd0);
        check("rst_data", d_o[0], 64'd0);
        check("rst_carry", 64'(c_o[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First transaction: exact latency and return to IDLE.
        v_in[0] = 1'b1;
        a_in[0] = 64'h5A;
        b_in[0] = 64'h3C;
        c_in[0] = 1'b0;
        r_in[0] = 1'b1;
        tick();
        v_in[0] = 1'b0;
        check("accept_ready_low", 64'(rdy_o[0]), 64'd0);
        repeat (7) tick();
        check("lat_not_early", 64'(v_o[0]), 64'd0);
        tick();
        check("lat_valid", 64'(v_o[0]), 64'd1);
        check("lat_data", d_o[0], 64'h96);
        check("lat_carry", 64'(c_o[0]), 64'd0);
        check("done_ready_low", 64'(rdy_o[0]), 64'd0);
        tick();
        check("after_valid", 64'(v_o[0]), 64'd0);
        check("after_ready", 64'(rdy_o[0]), 64'd1);
        r_in[0] = 1'b0;

        // Directed carry vectors; the last two scramble operands during RUN.
        for (int i = 0; i < 4; i++) begin
            run_req(0, vec_a[i], vec_b[i], vec_c[i], i % 2, (i >= 2), d, co, lat);
            check($sformatf("vec%0d_data", i), d, vec_d[i]);
            check($sformatf("vec%0d_carry", i), 64'(co), 64'(vec_o[i]));
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd8);
        end

        // Backpressure with pulsed requests while DONE.
        v_in[0] = 1'b1;
        a_in[0] = 64'h81;
        b_in[0] = 64'h7F;
        c_in[0] = 1'b1;
        tick();
        v_in[0] = 1'b0;
        repeat (8) tick();
        check("bp_valid_start", 64'(v_o[0]), 64'd1);
        held_d = d_o[0];
        check("bp_data_start", held_d, 64'h01);
        for (int i = 0; i < 5; i++) begin
            v_in[0] = 1'($urandom);
            a_in[0] = {$urandom, $urandom};
            b_in[0] = {$urandom, $urandom};
            tick();
            check("bp_valid", 64'(v_o[0]), 64'd1);
            check("bp_data", d_o[0], held_d);
            check("bp_carry", 64'(c_o[0]), 64'd1);
            check("bp_ready", 64'(rdy_o[0]), 64'd0);
        end
        v_in[0] = 1'b0;
        r_in[0] = 1'b1;
        tick();
        r_in[0] = 1'b0;
        check("bp_release_valid", 64'(v_o[0]), 64'd0);
        check("bp_release_ready", 64'(rdy_o[0]), 64'd1);
        seen = 0;
        repeat (12) begin
            tick();
            if (v_o[0]) seen++;
        end
        check("bp_no_second", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of RUN.
        v_in[0] = 1'b1;
        a_in[0] = 64'hAA;
        b_in[0] = 64'h55;
        c_in[0] = 1'b0;
        tick();
        v_in[0] = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(rdy_o[0]), 64'd1);
        check("mid_rst_valid", 64'(v_o[0]), 64'd0);
        check("mid_rst_data", d_o[0], 64'd0);
        check("mid_rst_carry", 64'(c_o[0]), 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            tick();
            if (v_o[0]) seen++;
        end
        check("mid_rst_no_valid", 64'(seen), 64'd0);
        run_req(0, 64'h12, 64'h34, 1'b0, 0, 1'b0, d, co, lat);
        check("post_rst_data", d, 64'h46);
        check("post_rst_carry", 64'(co), 64'd0);
        check("post_rst_lat", 64'(lat), 64'd8);

        // Random regression over all three widths.
        for (int s = 0; s < NS; s++) begin
            int          w;
            int          nreq;
            logic [63:0] a;
            logic [63:0] b;
            logic        c;
            logic [63:0] exp;
            w    = width_of(s);
            nreq = (s == 0) ? 400 : 300;
            for (int k = 0; k < nreq; k++) begin
                repeat ($urandom_range(0, 3)) tick();
                a   = {$urandom, $urandom} & mask_of(w);
                b   = {$urandom, $urandom} & mask_of(w);
                c   = 1'($urandom);
                exp = (a + b + 64'(c)) & mask_of(w + 1);
                run_req(s, a, b, c, $urandom_range(0, 3), 1'b1, d, co, lat);
                check($sformatf("rand_w%0d_sum", w), (64'(co) << w) | d, exp);
                check($sformatf("rand_w%0d_lat", w), 64'(lat), 64'(w));
                check($sformatf("rand_w%0d_single", w), {63'd0, v_o[s]}, {63'd0, ~rdy_o[s]});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
